// File: rtl/usb_ep_rd_ctrl_pkg.sv
// usb_ep_rd_ctrl shared types
// FSM encoding and FIFO beat layout
package usb_ep_rd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } rd_st_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/usb_ep_rd_fifo.sv
// usb_ep_rd_fifo: small beat FIFO with flush
// Push and pop may coincide at any occupancy
module usb_ep_rd_fifo
  import usb_ep_rd_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [BEAT_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BEAT_W-1:0] o_head,
  output logic [CW-1:0]     o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [BEAT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_count = r_count;
  // empty FIFO presents zero so idle output data is clean
  assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;

  // storage write; a flush drops the incoming beat
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush)
      r_mem[r_wptr] <= i_data;
  end

  // pointer and occupancy update
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/usb_ep_rd_ctrl.sv
// usb_ep_rd_ctrl: endpoint buffer read sequencer
// Turns (addr,len) into a valid/ready byte stream
module usb_ep_rd_ctrl
  import usb_ep_rd_ctrl_pkg::*;
#(
  parameter int AWIDTH     = 11,
  parameter int LWIDTH     = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [AWIDTH-1:0] buf_rd_addr_0,
  output logic              buf_rd_en_0,
  input  logic [7:0]        buf_rd_data_1,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_st_e            r_state;
  rd_st_e            w_nxt;
  logic [AWIDTH-1:0] r_addr;
  logic [LWIDTH-1:0] r_remain;
  logic              r_cap_vld;
  logic              r_cap_last;
  logic              r_aborted;
  logic              w_abort;
  logic              w_issue;
  logic              w_credit;
  logic              w_pop;
  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_occ;
  beat_t             w_push_beat;
  beat_t             w_head;

  assign w_abort  = cmd_abort & (r_state != ST_IDLE);
  assign w_occ    = w_cnt + CW'(r_cap_vld);
  assign w_credit = w_occ < CW'(FIFO_DEPTH);
  assign w_pop    = out_valid & out_ready;

  assign w_push_beat.last = r_cap_last;
  assign w_push_beat.data = buf_rd_data_1;

  assign busy          = r_state != ST_IDLE;
  assign done          = r_state == ST_FIN;
  assign aborted       = r_aborted;
  assign buf_rd_addr_0 = r_addr;
  assign buf_rd_en_0   = w_issue;
  assign out_valid     = w_cnt != '0;
  assign out_data      = w_head.data;
  assign out_last      = w_head.last;

  // next state and read issue; abort overrides all
  always_comb begin
    w_nxt   = r_state;
    w_issue = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // zero length passes through DRAIN,
        // so done lands two cycles after start
        if (cmd_start)
          w_nxt = (cmd_len != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        if (r_remain == '0) begin
          w_nxt = ST_DRAIN;
        end else if (w_credit) begin
          w_issue = 1'b1;
          if (r_remain == LWIDTH'(1))
            w_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_cap_vld &&
            (w_cnt == '0 ||
             (w_cnt == CW'(1) && w_pop)))
          w_nxt = ST_FIN;
      end
      ST_FIN: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_nxt   = ST_IDLE;
      w_issue = 1'b0;
    end
  end

  // state, address, count and capture pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_last <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_aborted  <= w_abort;
      r_cap_vld  <= w_issue;
      r_cap_last <= w_issue & (r_remain == LWIDTH'(1));
      if (r_state == ST_IDLE && cmd_start) begin
        r_addr   <= cmd_addr;
        r_remain <= cmd_len;
      end else if (w_issue) begin
        r_addr   <= r_addr + AWIDTH'(1);
        r_remain <= r_remain - LWIDTH'(1);
      end
    end
  end

  usb_ep_rd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flush(w_abort),
    .i_push (r_cap_vld),
    .i_data (w_push_beat),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_count(w_cnt)
  );

endmodule

// File: tb/tb_usb_ep_rd_ctrl.sv
// tb_usb_ep_rd_ctrl: directed bench
// Buffer model plus stream monitor
module tb_usb_ep_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [10:0] cmd_addr = '0;
  logic [10:0] cmd_len = '0;
  logic        cmd_abort = 1'b0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [10:0] buf_rd_addr_0;
  logic        buf_rd_en_0;
  logic [7:0]  buf_rd_data_1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  usb_ep_rd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_start    (cmd_start),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_abort    (cmd_abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .buf_rd_addr_0(buf_rd_addr_0),
    .buf_rd_en_0  (buf_rd_en_0),
    .buf_rd_data_1(buf_rd_data_1),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // buffer contents: byte = addr[7:0] ^ addr[10:8]
  logic [7:0] mem [2048];
  initial begin
    for (int i = 0; i < 2048; i++)
      mem[i] = 8'(i) ^ {5'b0, 3'(i >> 8)};
  end

  always @(posedge clk) begin
    if (buf_rd_en_0)
      buf_rd_data_1 <= mem[buf_rd_addr_0];
  end

  // monitor
  logic [8:0]  rx_q[$];
  logic [10:0] iss_q[$];
  logic        mon_clr = 1'b0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_beat = '0;
  int occ = 0;
  int max_occ = 0;
  int n_done = 0;
  int n_abt = 0;
  int n_iss = 0;
  int hold_err = 0;

  always @(posedge clk) begin
    if (done)
      n_done <= n_done + 1;
    if (aborted)
      n_abt <= n_abt + 1;
    if (buf_rd_en_0)
      n_iss <= n_iss + 1;
    if (rst || mon_clr) begin
      rx_q.delete();
      iss_q.delete();
      occ        <= 0;
      max_occ    <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        rx_q.push_back({out_last, out_data});
      if (buf_rd_en_0)
        iss_q.push_back(buf_rd_addr_0);
      if (prev_stall &&
          (!out_valid || {out_last, out_data} != prev_beat))
        hold_err <= hold_err + 1;
      prev_stall <= out_valid && !out_ready && !(cmd_abort && busy);
      prev_beat  <= {out_last, out_data};
      if (cmd_abort && busy)
        occ <= 0;
      else
        occ <= occ + int'(buf_rd_en_0) - int'(out_valid && out_ready);
      if (occ > max_occ)
        max_occ <= occ;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic start(input logic [10:0] a, input logic [10:0] l);
    cmd_start = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int c = 0;
    while (!done && c < maxc) begin
      tick();
      c++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  logic [10:0] wa[4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
  logic [7:0]  wd[4] = '{8'hF9, 8'hF8, 8'h00, 8'h01};

  initial begin
    int d0;
    int a0;
    int i0;
    int c;

    // reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abt", aborted, 0);
    chk("rst_en", buf_rd_en_0, 0);
    chk("rst_addr", buf_rd_addr_0, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    tick();

    // basic packet, exact latency
    out_ready = 1'b1;
    clr();
    start(11'h010, 11'd8);
    chk("b_busy1", busy, 1);
    chk("b_en1", buf_rd_en_0, 1);
    chk("b_addr1", buf_rd_addr_0, 11'h010);
    tick();
    chk("b_vld2", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b_vld", out_valid, 1);
      chk("b_data", out_data, 8'h10 + 8'(k));
      chk("b_last", out_last, (k == 7) ? 1 : 0);
    end
    tick();
    chk("b_done", done, 1);
    chk("b_busyf", busy, 1);
    tick();
    chk("b_busy0", busy, 0);
    chk("b_done0", done, 0);

    // back-pressure
    clr();
    out_ready = 1'b0;
    d0 = n_done;
    start(11'h020, 11'd16);
    c = 0;
    while (!done && c < 300) begin
      if (c < 16)
        out_ready = (c % 2 == 0);
      else if (c < 26)
        out_ready = 1'b0;
      else
        out_ready = 1'b1;
      tick();
      c++;
    end
    chk("bp_done", done, 1);
    tick();
    chk("bp_ndone", n_done - d0, 1);
    chk("bp_cnt", rx_q.size(), 16);
    for (int k = 0; k < 16 && k < rx_q.size(); k++)
      chk("bp_beat", rx_q[k], {(k == 15), 8'h20 + 8'(k)});
    chk("bp_occ", max_occ, 4);

    // zero length
    clr();
    i0 = n_iss;
    start(11'h050, 11'd0);
    chk("z_busy1", busy, 1);
    chk("z_done1", done, 0);
    tick();
    chk("z_busy2", busy, 1);
    chk("z_done2", done, 1);
    chk("z_vld2", out_valid, 0);
    tick();
    chk("z_busy3", busy, 0);
    chk("z_done3", done, 0);
    chk("z_iss", n_iss - i0, 0);

    // address wrap
    out_ready = 1'b1;
    clr();
    start(11'h7FE, 11'd4);
    wait_done("w_tmo", 50);
    tick();
    chk("w_icnt", iss_q.size(), 4);
    chk("w_rcnt", rx_q.size(), 4);
    for (int k = 0; k < 4 && k < iss_q.size(); k++)
      chk("w_addr", iss_q[k], wa[k]);
    for (int k = 0; k < 4 && k < rx_q.size(); k++)
      chk("w_beat", rx_q[k], {(k == 3), wd[k]});

    // abort mid-stream
    clr();
    d0 = n_done;
    a0 = n_abt;
    start(11'h040, 11'd32);
    c = 0;
    while (rx_q.size() < 5 && c < 50) begin
      tick();
      c++;
    end
    out_ready = 1'b0;
    chk("a_five", rx_q.size(), 5);
    tick();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("a_pulse", aborted, 1);
    chk("a_vld", out_valid, 0);
    chk("a_busy", busy, 0);
    tick();
    chk("a_pulse0", aborted, 0);
    repeat (5) tick();
    chk("a_nodone", n_done - d0, 0);
    chk("a_nabt", n_abt - a0, 1);
    chk("a_beat4", rx_q[4], {1'b0, 8'h44});
    out_ready = 1'b1;
    clr();
    start(11'h100, 11'd2);
    wait_done("a2_tmo", 50);
    tick();
    chk("a2_cnt", rx_q.size(), 2);
    chk("a2_b0", rx_q[0], {1'b0, 8'h01});
    chk("a2_b1", rx_q[1], {1'b1, 8'h00});

    // ignored start, credit stall, reset
    out_ready = 1'b0;
    clr();
    d0 = n_done;
    a0 = n_abt;
    start(11'h030, 11'd8);
    chk("i_addr1", buf_rd_addr_0, 11'h030);
    cmd_start = 1'b1;
    cmd_addr  = 11'h200;
    cmd_len   = 11'd3;
    tick();
    cmd_start = 1'b0;
    chk("i_addr2", buf_rd_addr_0, 11'h031);
    chk("i_en2", buf_rd_en_0, 1);
    tick();
    chk("i_addr3", buf_rd_addr_0, 11'h032);
    tick();
    chk("i_addr4", buf_rd_addr_0, 11'h033);
    chk("i_en4", buf_rd_en_0, 1);
    tick();
    chk("i_addr5", buf_rd_addr_0, 11'h034);
    chk("i_stall", buf_rd_en_0, 0);
    chk("i_head", out_data, 8'h30);
    rst = 1'b1;
    tick();
    chk("r_busy", busy, 0);
    chk("r_en", buf_rd_en_0, 0);
    chk("r_addr", buf_rd_addr_0, 0);
    chk("r_vld", out_valid, 0);
    chk("r_data", out_data, 0);
    chk("r_last", out_last, 0);
    chk("r_done", done, 0);
    chk("r_abt", aborted, 0);
    rst = 1'b0;
    tick();
    chk("r_nodone", n_done - d0, 0);
    chk("r_noabt", n_abt - a0, 0);
    out_ready = 1'b1;
    clr();
    start(11'h005, 11'd1);
    wait_done("r2_tmo", 50);
    tick();
    chk("r2_cnt", rx_q.size(), 1);
    chk("r2_b0", rx_q[0], {1'b1, 8'h05});

    chk("hold", hold_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
